// File: rtl/case_1_prod_accum_pkg.sv
// Shared types and width constants for the product accumulator.
package case_1_prod_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int CNT_WIDTH     = 10;
  localparam int DIN_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF = 16;

endpackage

// File: rtl/case_1_prod_accum_if.sv
// Product-in / result-out handshake bundle, plus the synchronous clear.
interface case_1_prod_accum_if
  import case_1_prod_accum_pkg::*;
#(
  parameter int din_WIDTH = DIN_WIDTH_DEF,
  parameter int acc_WIDTH = ACC_WIDTH_DEF
);
  logic                        clr;
  logic signed [din_WIDTH-1:0] in_data;
  logic                        in_vld;
  logic                        in_rdy;
  logic signed [acc_WIDTH-1:0] out_data;
  logic                        out_vld;
  logic                        out_rdy;
  logic                        out_ovf;

  modport master (
    output clr, in_data, in_vld, out_rdy,
    input  in_rdy, out_data, out_vld, out_ovf
  );

  modport slave (
    input  clr, in_data, in_vld, out_rdy,
    output in_rdy, out_data, out_vld, out_ovf
  );
endinterface

// File: rtl/case_1_prod_accum_sat_add.sv
// Combinational accumulator adder (module case_1_sat_add): clamps to the acc range
// when CASE_1_PROD_ACCUM_SAT_EN is defined, otherwise wraps and reports no overflow.
module case_1_sat_add #(
  parameter int din_WIDTH = 8,
  parameter int acc_WIDTH = 16
) (
  input  logic signed [acc_WIDTH-1:0] a,
  input  logic signed [din_WIDTH-1:0] b,
  output logic signed [acc_WIDTH-1:0] sum,
  output logic                        ovf
);
`ifdef CASE_1_PROD_ACCUM_SAT_EN
  localparam int WW = acc_WIDTH + 1;
  logic signed [acc_WIDTH:0] wide;

  assign wide = WW'(a) + WW'(b);
  // Top two bits disagree exactly when the true sum left the acc range.
  assign ovf  = wide[acc_WIDTH] ^ wide[acc_WIDTH-1];

  always_comb begin
    sum = wide[acc_WIDTH-1:0];
    if (ovf) begin
      sum = wide[acc_WIDTH] ? {1'b1, {(acc_WIDTH-1){1'b0}}}
                            : {1'b0, {(acc_WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = a + acc_WIDTH'(b);
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/case_1_prod_accum.sv
// Sums LEN signed products per result; optional saturation via CASE_1_PROD_ACCUM_SAT_EN.
// state | meaning: ACCUM | taking beats (in_rdy=1) ; HOLD | result pending (out_vld=1)
module case_1_prod_accum
  import case_1_prod_accum_pkg::*;
#(
  parameter int din_WIDTH = DIN_WIDTH_DEF,
  parameter int acc_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN       = 8
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  case_1_prod_accum_if.slave bus
);

  state_t                      state;
  logic signed [acc_WIDTH-1:0] acc;
  logic signed [acc_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        sticky;
  logic                        clamp;
  logic                        take;
  logic                        last;

  // clr wins over acceptance: a beat presented alongside clr is dropped.
  assign take = bus.in_vld && bus.in_rdy && !bus.clr;
  assign last = (cnt == CNT_WIDTH'(LEN - 1));

  case_1_sat_add #(
    .din_WIDTH(din_WIDTH),
    .acc_WIDTH(acc_WIDTH)
  ) u_sat_add (
    .a  (acc),
    .b  (bus.in_data),
    .sum(sum),
    .ovf(clamp)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
      bus.in_rdy   <= 1'b1;
      bus.out_vld  <= 1'b0;
      bus.out_data <= '0;
      bus.out_ovf  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            if (last) begin
              bus.out_data <= sum;
              bus.out_ovf  <= sticky | clamp;
              bus.out_vld  <= 1'b1;
              bus.in_rdy   <= 1'b0;
              acc          <= '0;
              cnt          <= '0;
              sticky       <= 1'b0;
              state        <= HOLD;
            end else begin
              acc    <= sum;
              cnt    <= cnt + 1'b1;
              sticky <= sticky | clamp;
            end
          end
        end
        HOLD: begin
          if (bus.out_rdy) begin
            bus.out_vld <= 1'b0;
            bus.in_rdy  <= 1'b1;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
      // Only partial-sum state is cleared; a held result survives clr.
      if (bus.clr) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_case_1_prod_accum.sv
// Self-checking bench: directed scenarios plus a randomized scoreboard run.
module tb_case_1_prod_accum;

  localparam int MAXV = 32767;
  localparam int MINV = -32768;
  localparam int MODV = 65536;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 ap_clk = ~ap_clk;

  case_1_prod_accum_if #(.din_WIDTH(8), .acc_WIDTH(16)) b4 ();
  case_1_prod_accum_if #(.din_WIDTH(8), .acc_WIDTH(16)) b300 ();

  case_1_prod_accum #(.din_WIDTH(8), .acc_WIDTH(16), .LEN(4)) dut4 (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (b4)
  );

  case_1_prod_accum #(.din_WIDTH(8), .acc_WIDTH(16), .LEN(300)) dut300 (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (b300)
  );

  // Reference: sum beats one addition at a time, clamping or wrapping each step.
  function automatic void model_frame(input int beats[$], output int sum, output bit ovf);
    sum = 0;
    ovf = 1'b0;
    foreach (beats[i]) begin
      sum += beats[i];
`ifdef CASE_1_PROD_ACCUM_SAT_EN
      if (sum > MAXV) begin sum = MAXV; ovf = 1'b1; end
      else if (sum < MINV) begin sum = MINV; ovf = 1'b1; end
`else
      while (sum > MAXV) sum -= MODV;
      while (sum < MINV) sum += MODV;
`endif
    end
  endfunction

  task automatic send4(input int d);
    int  n     = 0;
    bit  taken = 1'b0;
    b4.in_data = 8'(d);
    b4.in_vld  = 1'b1;
    while (!taken && n < 100) begin
      taken = b4.in_rdy;
      @(posedge ap_clk); #1;
      n++;
    end
    b4.in_vld = 1'b0;
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL send_beat: beat %0d not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic test_reset();
    b4.clr = 0; b4.in_vld = 0; b4.in_data = '0; b4.out_rdy = 1;
    b300.clr = 0; b300.in_vld = 0; b300.in_data = '0; b300.out_rdy = 1;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (b4.out_vld !== 1'b0 || b4.out_data !== 16'sd0 || b4.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b data=%0d ovf=%b, want 0 0 0",
               b4.out_vld, b4.out_data, b4.out_ovf);
    end
    checks++;
    if (b300.out_vld !== 1'b0 || b300.out_data !== 16'sd0 || b300.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_300: vld=%b data=%0d ovf=%b, want 0 0 0",
               b300.out_vld, b300.out_data, b300.out_ovf);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (b4.in_rdy !== 1'b1 || b4.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_rdy=%b out_vld=%b, want 1 0", b4.in_rdy, b4.out_vld);
    end
  endtask

  task automatic test_basic();
    b4.out_rdy = 1;
    send4(10); send4(-3); send4(127);
    checks++;
    if (b4.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: out_vld=%b after 3 beats, want 0", b4.out_vld);
    end
    send4(-128);
    checks++;
    if (b4.out_vld !== 1'b1 || int'(b4.out_data) !== 6 || b4.out_ovf !== 1'b0 || b4.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: vld=%b data=%0d ovf=%b in_rdy=%b, want 1 6 0 0",
               b4.out_vld, b4.out_data, b4.out_ovf, b4.in_rdy);
    end
    @(posedge ap_clk); #1;
    checks++;
    if (b4.out_vld !== 1'b0 || b4.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_consume: out_vld=%b in_rdy=%b, want 0 1", b4.out_vld, b4.in_rdy);
    end
  endtask

  task automatic test_backpressure();
    b4.out_rdy = 0;
    send4(10); send4(-3); send4(127); send4(-128);
    b4.in_vld  = 1;
    b4.in_data = 8'sd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      checks++;
      if (b4.in_rdy !== 1'b0 || b4.out_vld !== 1'b1 || int'(b4.out_data) !== 6) begin
        errors++;
        $display("FAIL hold_stable[%0d]: in_rdy=%b vld=%b data=%0d, want 0 1 6",
                 i, b4.in_rdy, b4.out_vld, b4.out_data);
      end
    end
    b4.in_vld = 0;
    b4.clr    = 1;
    @(posedge ap_clk); #1;
    b4.clr = 0;
    checks++;
    if (b4.out_vld !== 1'b1 || int'(b4.out_data) !== 6) begin
      errors++;
      $display("FAIL clr_in_hold: vld=%b data=%0d, want 1 6", b4.out_vld, b4.out_data);
    end
    b4.out_rdy = 1;
    send4(1); send4(2); send4(3); send4(4);
    checks++;
    if (b4.out_vld !== 1'b1 || int'(b4.out_data) !== 10) begin
      errors++;
      $display("FAIL back_to_back: vld=%b data=%0d, want 1 10", b4.out_vld, b4.out_data);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_sat();
    int n_acc = 0;
    int cyc   = 0;
    int exp_d;
    bit exp_o;
`ifdef CASE_1_PROD_ACCUM_SAT_EN
    exp_d = 32767;  exp_o = 1'b1;
`else
    exp_d = -27436; exp_o = 1'b0;
`endif
    b300.out_rdy = 1;
    b300.in_data = 8'sd127;
    b300.in_vld  = 1;
    while (n_acc < 300 && cyc < 1000) begin
      if (b300.in_rdy) n_acc++;
      @(posedge ap_clk); #1;
      cyc++;
    end
    b300.in_vld = 0;
    checks++;
    if (n_acc != 300) begin
      errors++;
      $display("FAIL sat_timeout: accepted %0d beats, want 300", n_acc);
    end
    checks++;
    if (b300.out_vld !== 1'b1 || int'(b300.out_data) !== exp_d || b300.out_ovf !== exp_o) begin
      errors++;
      $display("FAIL sat_result: vld=%b data=%0d ovf=%b, want 1 %0d %b",
               b300.out_vld, b300.out_data, b300.out_ovf, exp_d, exp_o);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_clr();
    b4.out_rdy = 1;
    send4(5); send4(5);
    b4.clr     = 1;
    b4.in_vld  = 1;
    b4.in_data = 8'sd9;
    @(posedge ap_clk); #1;
    b4.clr    = 0;
    b4.in_vld = 0;
    send4(1); send4(1); send4(1); send4(1);
    checks++;
    if (b4.out_vld !== 1'b1 || int'(b4.out_data) !== 4) begin
      errors++;
      $display("FAIL clr_abort: vld=%b data=%0d, want 1 4", b4.out_vld, b4.out_data);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_midframe();
    b4.out_rdy = 1;
    send4(7); send4(7);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if (b4.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: out_vld=%b, want 0", b4.out_vld);
    end
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge ap_clk); #1;
      checks++;
      if (b4.out_vld !== 1'b0 || b4.in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_idle[%0d]: out_vld=%b in_rdy=%b, want 0 1", i, b4.out_vld, b4.in_rdy);
      end
    end
    send4(1); send4(2); send4(3); send4(4);
    checks++;
    if (b4.out_vld !== 1'b1 || int'(b4.out_data) !== 10) begin
      errors++;
      $display("FAIL rst_mid_next: vld=%b data=%0d, want 1 10", b4.out_vld, b4.out_data);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_hold();
    b4.out_rdy = 0;
    send4(1); send4(1); send4(1); send4(1);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if (b4.out_vld !== 1'b0 || b4.out_data !== 16'sd0) begin
      errors++;
      $display("FAIL rst_hold: vld=%b data=%0d, want 0 0", b4.out_vld, b4.out_data);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (b4.out_vld !== 1'b0 || b4.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_release: out_vld=%b in_rdy=%b, want 0 1", b4.out_vld, b4.in_rdy);
    end
    b4.out_rdy = 1;
  endtask

  task automatic test_random();
    int exp_d[$];
    bit exp_o[$];
    int frame[$];
    int got = 0;
    int cyc = 0;
    int d, es;
    bit eo, acc_now, out_now;
    b4.clr = 0;
    while (got < 1000 && cyc < 40000) begin
      d          = int'($urandom_range(0, 255)) - 128;
      b4.in_data = 8'(d);
      b4.in_vld  = ($urandom_range(0, 3) != 0);
      b4.out_rdy = ($urandom_range(0, 2) != 0);
      acc_now    = b4.in_vld && b4.in_rdy;
      out_now    = b4.out_vld && b4.out_rdy;
      if (out_now) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected result %0d at frame %0d", b4.out_data, got);
        end else begin
          es = exp_d.pop_front();
          eo = exp_o.pop_front();
          if (int'(b4.out_data) !== es || b4.out_ovf !== eo) begin
            errors++;
            $display("FAIL rand_result[%0d]: data=%0d ovf=%b, want %0d %b",
                     got, b4.out_data, b4.out_ovf, es, eo);
          end
        end
        got++;
      end
      @(posedge ap_clk); #1;
      cyc++;
      if (acc_now) begin
        frame.push_back(d);
        if (frame.size() == 4) begin
          model_frame(frame, es, eo);
          exp_d.push_back(es);
          exp_o.push_back(eo);
          frame.delete();
        end
      end
    end
    b4.in_vld  = 0;
    b4.out_rdy = 1;
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL rand_count: %0d results in %0d cycles, want 1000", got, cyc);
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sat();
    test_clr();
    test_reset_midframe();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
